// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcode constants and hazard history entry type
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       valid_load;
        logic [4:0] rd;
    } hist_entry_t;

endpackage

// File: rtl/opcode_classifier.sv
// rtl/opcode_classifier.sv - decode opcode into register-usage and load flags
module opcode_classifier
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       writes_rd,
    output logic       is_load
);

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        case (opcode)
            OP_R: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_IMM, OP_JALR: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_LOAD: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_JAL, OP_LUI, OP_AUIPC: begin
                writes_rd = 1'b1;
            end
            default: begin
                uses_rs1  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use hazard detector for the 5-stage in-order core
module hazard_stall_unit
    import riscv_pkg::*;
#(
    parameter int HAZARD_WINDOW = 1,
    parameter int ADDR_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4:0]            reg_src_a,
    input  logic [4:0]            reg_src_b,
    input  logic [4:0]            reg_dest,
    input  logic [6:0]            opcode,
    input  logic [ADDR_WIDTH-1:0] mem_src,
    input  logic [ADDR_WIDTH-1:0] mem_dest,
    output logic                  stall
);

    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
    logic is_load;

    hist_entry_t                    hist_q [HAZARD_WINDOW];
    hist_entry_t                    hist_d [HAZARD_WINDOW];
    logic        [HAZARD_WINDOW-1:0] hit;

    // EX-stage results are carried on the interface only; they never influence the stall.
    logic unused_mem;
    assign unused_mem = ^{mem_src, mem_dest};

    opcode_classifier u_classifier (
        .opcode    (opcode),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .writes_rd (writes_rd),
        .is_load   (is_load)
    );

    for (genvar i = 0; i < HAZARD_WINDOW; i++) begin : g_cmp
        assign hit[i] = hist_q[i].valid_load && (hist_q[i].rd != 5'd0) &&
                        ((uses_rs1 && (hist_q[i].rd == reg_src_b)) ||
                         (uses_rs2 && (hist_q[i].rd == reg_src_a)));
    end

    assign stall = !reset && !start && (|hit);

    // A stalled slot enters history as a bubble; the held instruction is pushed on its retry.
    always_comb begin
        hist_d[0].valid_load = !stall && is_load && writes_rd && (reg_dest != 5'd0);
        hist_d[0].rd         = stall ? 5'd0 : reg_dest;
        for (int i = 1; i < HAZARD_WINDOW; i++) begin
            hist_d[i] = hist_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            for (int i = 0; i < HAZARD_WINDOW; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < HAZARD_WINDOW; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - self-checking scoreboard bench for hazard_stall_unit
module tb_hazard_stall_unit;
    import riscv_pkg::*;

    typedef struct {
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       exp;
    } row_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  reg_src_a;
    logic [4:0]  reg_src_b;
    logic [4:0]  reg_dest;
    logic [6:0]  opcode;
    logic [31:0] mem_src;
    logic [31:0] mem_dest;
    logic        stall;

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];

    hazard_stall_unit #(.HAZARD_WINDOW(1), .ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .reg_src_a (reg_src_a),
        .reg_src_b (reg_src_b),
        .reg_dest  (reg_dest),
        .opcode    (opcode),
        .mem_src   (mem_src),
        .mem_dest  (mem_dest),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input logic [6:0] op, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic exp);
        row_t r;
        r.op = op; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.exp = exp;
        return r;
    endfunction

    task automatic drive_row(input row_t r);
        @(posedge clk);
        #1;
        opcode    = r.op;
        reg_src_b = r.rs1;
        reg_src_a = r.rs2;
        reg_dest  = r.rd;
        mem_src   = $urandom_range(0, 1) ? 32'hDEADBEEF : 32'h0;
        mem_dest  = $urandom_range(0, 1) ? mem_src : ~mem_src;
        exp_q.push_back(r.exp);
    endtask

    task automatic test_reset();
        logic got;
        reset = 1'b1;
        start = 1'b0;
        drive_row(mk(OP_R, 5'd5, 5'd5, 5'd6, 1'b0));
        @(negedge clk);
        got = exp_q.pop_front();
        checks++;
        if (stall !== got) begin
            errors++;
            $display("FAIL reset_hold: stall=%b expected=%b", stall, got);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: stall=%b expected=0", stall);
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        logic got;
        rows = '{mk(OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0),
                 mk(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0),
                 mk(OP_R, 5'd5, 5'd2, 5'd6, 1'b1),
                 mk(OP_R, 5'd5, 5'd2, 5'd6, 1'b0),
                 mk(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0),
                 mk(OP_R, 5'd1, 5'd5, 5'd6, 1'b1),
                 mk(OP_R, 5'd1, 5'd5, 5'd6, 1'b0),
                 mk(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0),
                 mk(OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0),
                 mk(OP_R, 5'd5, 5'd2, 5'd6, 1'b0)};
        foreach (rows[k]) begin
            drive_row(rows[k]);
            @(negedge clk);
            got = exp_q.pop_front();
            checks++;
            if (stall !== got) begin
                errors++;
                $display("FAIL load_use[%0d]: stall=%b expected=%b", k, stall, got);
            end
        end
    endtask

    task automatic test_x0_and_producers();
        row_t rows[$];
        logic got;
        rows = '{mk(OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0),
                 mk(OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b0),
                 mk(OP_R, 5'd0, 5'd0, 5'd6, 1'b0),
                 mk(OP_IMM, 5'd1, 5'd0, 5'd5, 1'b0),
                 mk(OP_R, 5'd5, 5'd5, 5'd6, 1'b0),
                 mk(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0),
                 mk(OP_IMM, 5'd2, 5'd5, 5'd8, 1'b0),
                 mk(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0),
                 mk(7'b1111111, 5'd5, 5'd5, 5'd9, 1'b0),
                 mk(OP_R, 5'd5, 5'd0, 5'd6, 1'b0)};
        foreach (rows[k]) begin
            drive_row(rows[k]);
            @(negedge clk);
            got = exp_q.pop_front();
            checks++;
            if (stall !== got) begin
                errors++;
                $display("FAIL x0_producers[%0d]: stall=%b expected=%b", k, stall, got);
            end
        end
    endtask

    task automatic test_store_branch();
        row_t rows[$];
        logic got;
        rows = '{mk(OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0),
                 mk(OP_LOAD, 5'd1, 5'd0, 5'd7, 1'b0),
                 mk(OP_STORE, 5'd2, 5'd7, 5'd4, 1'b1),
                 mk(OP_STORE, 5'd2, 5'd7, 5'd4, 1'b0),
                 mk(OP_LOAD, 5'd1, 5'd0, 5'd7, 1'b0),
                 mk(OP_LUI, 5'd7, 5'd7, 5'd7, 1'b0),
                 mk(OP_LOAD, 5'd1, 5'd0, 5'd7, 1'b0),
                 mk(OP_BRANCH, 5'd7, 5'd3, 5'd0, 1'b1),
                 mk(OP_BRANCH, 5'd7, 5'd3, 5'd0, 1'b0),
                 mk(OP_LOAD, 5'd1, 5'd0, 5'd7, 1'b0),
                 mk(OP_JALR, 5'd7, 5'd0, 5'd1, 1'b1),
                 mk(OP_JALR, 5'd7, 5'd0, 5'd1, 1'b0)};
        foreach (rows[k]) begin
            drive_row(rows[k]);
            @(negedge clk);
            got = exp_q.pop_front();
            checks++;
            if (stall !== got) begin
                errors++;
                $display("FAIL store_branch[%0d]: stall=%b expected=%b", k, stall, got);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        logic got;
        rows = '{mk(OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0),
                 mk(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0),
                 mk(OP_LOAD, 5'd5, 5'd0, 5'd6, 1'b1),
                 mk(OP_LOAD, 5'd5, 5'd0, 5'd6, 1'b0),
                 mk(OP_R, 5'd6, 5'd6, 5'd7, 1'b1),
                 mk(OP_R, 5'd6, 5'd6, 5'd7, 1'b0),
                 mk(OP_R, 5'd7, 5'd6, 5'd8, 1'b0)};
        foreach (rows[k]) begin
            drive_row(rows[k]);
            @(negedge clk);
            got = exp_q.pop_front();
            checks++;
            if (stall !== got) begin
                errors++;
                $display("FAIL back_to_back[%0d]: stall=%b expected=%b", k, stall, got);
            end
        end
    endtask

    task automatic test_clear_mid_stall(input bit use_start);
        row_t rows[$];
        logic got;
        rows = '{mk(OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0),
                 mk(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0),
                 mk(OP_R, 5'd5, 5'd2, 5'd6, 1'b1)};
        foreach (rows[k]) begin
            drive_row(rows[k]);
            @(negedge clk);
            got = exp_q.pop_front();
            checks++;
            if (stall !== got) begin
                errors++;
                $display("FAIL clear_pre[%0d] start=%0b: stall=%b expected=%b",
                         k, use_start, stall, got);
            end
        end
        if (use_start) start = 1'b1;
        else           reset = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL clear_same_cycle start=%0b: stall=%b expected=0", use_start, stall);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        rows = '{mk(OP_R, 5'd5, 5'd2, 5'd6, 1'b0),
                 mk(OP_R, 5'd5, 5'd2, 5'd6, 1'b0)};
        foreach (rows[k]) begin
            drive_row(rows[k]);
            @(negedge clk);
            got = exp_q.pop_front();
            checks++;
            if (stall !== got) begin
                errors++;
                $display("FAIL clear_post[%0d] start=%0b: stall=%b expected=%b",
                         k, use_start, stall, got);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        opcode    = OP_IMM;
        reg_src_a = 5'd0;
        reg_src_b = 5'd0;
        reg_dest  = 5'd0;
        mem_src   = 32'h0;
        mem_dest  = 32'h0;
        repeat (2) @(posedge clk);
        test_reset();
        test_load_use();
        test_x0_and_producers();
        test_store_branch();
        test_back_to_back();
        test_clear_mid_stall(1'b0);
        test_clear_mid_stall(1'b1);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
